// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encoding.
package pll_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

endpackage

// File: rtl/pll_reset_sequencer_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear; shared by clock-crossing blocks.
module sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives PLL/DCM reset, qualifies LOCKED, and releases the system reset once lock is stable.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 8,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned RETRY_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               soft_req,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic               lock_ok,
  output logic [RETRY_W-1:0] retry_count,
  output logic               timeout_err
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               terr_q, terr_d;
  logic               pll_rst_q, sys_rst_n_q, lock_ok_q;
  logic               lk_s;
  logic               retry_inc;

  sync2 u_lock_sync (
    .clk_i (clk),
    .rst_ni(rst_n),
    .d_i   (pll_locked),
    .q_o   (lk_s)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    retry_d   = retry_q;
    terr_d    = terr_q;
    retry_inc = 1'b0;

    unique case (state_q)
      ST_PLL_RST: begin
        if (timer_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lk_s) begin
          state_d = ST_STABLE;
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d   = ST_PLL_RST;
          retry_inc = 1'b1;
          terr_d    = 1'b1;
        end
      end
      ST_STABLE: begin
        if (!lk_s) state_d = ST_WAIT_LOCK;
        else if (timer_q == STABLE_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!lk_s) begin
          state_d   = ST_PLL_RST;
          retry_inc = 1'b1;
        end
      end
      default: state_d = ST_PLL_RST;
    endcase

    // A soft request overrides whatever transition the state logic chose, including its side effects.
    if (soft_req) begin
      state_d   = ST_PLL_RST;
      retry_inc = 1'b0;
      terr_d    = terr_q;
    end

    if (retry_inc && (retry_q != '1)) retry_d = retry_q + 1'b1;

    if ((state_d != state_q) || soft_req) timer_d = '0;
    else if (state_q != ST_RUN)           timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PLL_RST;
      timer_q     <= '0;
      retry_q     <= '0;
      terr_q      <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      lock_ok_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      terr_q      <= terr_d;
      pll_rst_q   <= (state_d == ST_PLL_RST);
      sys_rst_n_q <= (state_d == ST_RUN);
      lock_ok_q   <= (state_d == ST_RUN);
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst_n   = sys_rst_n_q;
  assign lock_ok     = lock_ok_q;
  assign retry_count = retry_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed scoreboard bench for pll_reset_sequencer with short timing parameters.
module tb_pll_reset_sequencer;
  import pll_reset_sequencer_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic       soft_req;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       lock_ok;
  logic [3:0] retry_count;
  logic       timeout_err;

  int vectors;
  int miscompares;

  typedef struct {
    string      tag;
    state_e     st;
    logic       p;
    logic       s;
    logic       l;
    logic [3:0] r;
    logic       t;
  } exp_t;

  exp_t sbq[$];

  pll_reset_sequencer #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .CNT_W        (16),
    .RETRY_W      (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .soft_req   (soft_req),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .lock_ok    (lock_ok),
    .retry_count(retry_count),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1);
  end

  function automatic logic [3:0] sat(input int n);
    return (n > 15) ? 4'hF : 4'(n);
  endfunction

  task automatic cmp(input string tag, input string fld, input logic [3:0] obs, input logic [3:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s/%s: observed %0h expected %0h", tag, fld, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_check();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      cmp(e.tag, "state",       4'(dut.state_q), 4'(e.st));
      cmp(e.tag, "pll_rst",     4'(pll_rst),     4'(e.p));
      cmp(e.tag, "sys_rst_n",   4'(sys_rst_n),   4'(e.s));
      cmp(e.tag, "lock_ok",     4'(lock_ok),     4'(e.l));
      cmp(e.tag, "retry_count", retry_count,     e.r);
      cmp(e.tag, "timeout_err", 4'(timeout_err), 4'(e.t));
    end
  endtask

  // Push the expectation, advance n cycles, then compare against the DUT.
  task automatic sc(input int n, input string tag, input state_e st, input logic p, input logic s,
                    input logic l, input logic [3:0] r, input logic t);
    exp_t e;
    e.tag = tag; e.st = st; e.p = p; e.s = s; e.l = l; e.r = r; e.t = t;
    sbq.push_back(e);
    repeat (n) tick();
    sb_check();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    pll_locked  = 1'b0;
    soft_req    = 1'b0;

    // Power-up: reset values, then PLL reset pulse and delayed lock.
    repeat (3) tick();
    sc(0, "por", ST_PLL_RST, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    rst_n = 1'b1;
    sc(0, "rel", ST_PLL_RST, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 1; i <= 3; i++) sc(1, "rst_hi", ST_PLL_RST, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    sc(1, "rst_lo",   ST_WAIT_LOCK, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    sc(3, "wait3",    ST_WAIT_LOCK, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    pll_locked = 1'b1;
    sc(2, "sync_lat", ST_WAIT_LOCK, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    sc(1, "stab0",    ST_STABLE,    1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    sc(7, "stab7",    ST_STABLE,    1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    sc(1, "run",      ST_RUN,       1'b0, 1'b1, 1'b1, 4'd0, 1'b0);

    // One-cycle lock loss in RUN.
    pll_locked = 1'b0;
    sc(1, "ll_c1", ST_RUN, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
    pll_locked = 1'b1;
    sc(1, "ll_c2",   ST_RUN,       1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
    sc(1, "ll_c3",   ST_PLL_RST,   1'b1, 1'b0, 1'b0, 4'd1, 1'b0);
    sc(3, "ll_rst",  ST_PLL_RST,   1'b1, 1'b0, 1'b0, 4'd1, 1'b0);
    sc(1, "ll_wait", ST_WAIT_LOCK, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
    sc(1, "ll_stab", ST_STABLE,    1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
    sc(7, "ll_st7",  ST_STABLE,    1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
    sc(1, "ll_run",  ST_RUN,       1'b0, 1'b1, 1'b1, 4'd1, 1'b0);

    // Soft request from RUN.
    soft_req = 1'b1;
    sc(1, "sr_run", ST_PLL_RST, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0);
    soft_req = 1'b0;
    sc(3, "sr_hi",   ST_PLL_RST,   1'b1, 1'b0, 1'b0, 4'd1, 1'b0);
    sc(1, "sr_wait", ST_WAIT_LOCK, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
    sc(1, "sr_stab", ST_STABLE,    1'b0, 1'b0, 1'b0, 4'd1, 1'b0);

    // Lock glitch seen by the FSM while the STABLE timer is at 5.
    sc(3, "gl_t3", ST_STABLE, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
    pll_locked = 1'b0;
    sc(1, "gl_t4", ST_STABLE, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
    pll_locked = 1'b1;
    sc(1, "gl_t5",    ST_STABLE,    1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
    sc(1, "gl_wait",  ST_WAIT_LOCK, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
    sc(1, "gl_restab", ST_STABLE,   1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
    sc(1, "gl_norun", ST_STABLE,    1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
    sc(6, "gl_st7",   ST_STABLE,    1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
    sc(1, "gl_run",   ST_RUN,       1'b0, 1'b1, 1'b1, 4'd1, 1'b0);

    // Lock loss, then soft request coinciding with lock timeout.
    pll_locked = 1'b0;
    sc(2,  "lt_run",  ST_RUN,       1'b0, 1'b1, 1'b1, 4'd1, 1'b0);
    sc(1,  "lt_rst",  ST_PLL_RST,   1'b1, 1'b0, 1'b0, 4'd2, 1'b0);
    sc(4,  "lt_wait", ST_WAIT_LOCK, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);
    sc(19, "lt_t19",  ST_WAIT_LOCK, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);
    soft_req = 1'b1;
    sc(1, "sr_to", ST_PLL_RST, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0);
    soft_req = 1'b0;

    // Async reset mid WAIT_LOCK with retry_count=2.
    sc(4, "pre_w0", ST_WAIT_LOCK, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);
    sc(5, "pre_w5", ST_WAIT_LOCK, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);
    rst_n = 1'b0;
    #1;
    sc(0, "arst_wait", ST_PLL_RST, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    sc(2, "arst_hold", ST_PLL_RST, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    rst_n = 1'b1;

    // No lock: repeated timeouts every 24 cycles, retry_count saturates.
    for (int n = 1; n <= 20; n++) begin
      logic [3:0] rp;
      logic [3:0] rn;
      logic       tp;
      rp = sat(n - 1);
      rn = sat(n);
      tp = (n > 1);
      sc(3,  "to_rsthi", ST_PLL_RST,   1'b1, 1'b0, 1'b0, rp, tp);
      sc(1,  "to_wait",  ST_WAIT_LOCK, 1'b0, 1'b0, 1'b0, rp, tp);
      sc(19, "to_last",  ST_WAIT_LOCK, 1'b0, 1'b0, 1'b0, rp, tp);
      sc(1,  "to_exp",   ST_PLL_RST,   1'b1, 1'b0, 1'b0, rn, 1'b1);
    end

    // Async reset clears saturated count and sticky error.
    sc(10, "sat_wait", ST_WAIT_LOCK, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1);
    rst_n = 1'b0;
    #1;
    sc(0, "arst_sat", ST_PLL_RST, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);

    // Lock present from release: RUN after 4+1+8 cycles; reset drops sys_rst_n at once.
    pll_locked = 1'b1;
    tick();
    rst_n = 1'b1;
    sc(12, "fast_st", ST_STABLE, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    sc(1,  "fast_run", ST_RUN,   1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    sc(0, "arst_run", ST_PLL_RST, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
